// File: rtl/tlul_sram_adapter.sv
// rtl/tlul_sram_adapter.sv - TL-UL device port bridged to a single-port SRAM with in-order responses
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

endpackage

module tlul_sram_adapter #(
    parameter int SramAw      = 12,
    parameter int Outstanding = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  tlul_pkg::tl_h2d_t   tl_i,
    output tlul_pkg::tl_d2h_t   tl_o,
    output logic                req_o,
    input  logic                gnt_i,
    output logic                we_o,
    output logic [SramAw-1:0]   addr_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         wmask_o,
    input  logic [31:0]         rdata_i,
    input  logic                rvalid_i
);
    import tlul_pkg::*;

    localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int CntW = $clog2(Outstanding + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Outstanding - 1);
    localparam logic [CntW-1:0] Depth   = CntW'(Outstanding);

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] size;
        logic [7:0] source;
        logic       error;
        logic       is_read;
    } entry_t;

    entry_t            entries   [Outstanding];
    logic [31:0]       rdata_q   [Outstanding];
    logic [Outstanding-1:0] data_valid;

    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CntW-1:0]   count;
    logic              rd_pend;
    logic [PtrW-1:0]   rd_slot;

    logic              op_get;
    logic              op_put_full;
    logic              op_known;
    logic [3:0]        span;
    logic              misaligned;
    logic              size_bad;
    logic              mask_short;
    logic              a_err;
    logic              not_full;
    logic              a_ready;
    logic              accept;
    logic              pop;
    logic              d_valid;
    entry_t            head;
    entry_t            new_entry;
    logic [31:0]       d_data;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Request checks: the byte span a request covers decides both alignment and full-mask coverage.
    always_comb begin
        op_get      = (tl_i.a_opcode == Get);
        op_put_full = (tl_i.a_opcode == PutFullData);
        op_known    = op_get || op_put_full || (tl_i.a_opcode == PutPartialData);
        size_bad    = (tl_i.a_size == 2'd3);
        case (tl_i.a_size)
            2'd0: begin
                span       = 4'b0001 << tl_i.a_address[1:0];
                misaligned = 1'b0;
            end
            2'd1: begin
                span       = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
                misaligned = tl_i.a_address[0];
            end
            default: begin
                span       = 4'b1111;
                misaligned = |tl_i.a_address[1:0];
            end
        endcase
        mask_short = op_put_full && ((tl_i.a_mask & span) != span);
        a_err      = !op_known || size_bad || misaligned || mask_short;
    end

    assign not_full = (count != Depth);
    assign a_ready  = !reset && not_full && (gnt_i || a_err);
    assign req_o    = !reset && tl_i.a_valid && !a_err && not_full;
    assign accept   = tl_i.a_valid && a_ready;

    assign we_o    = !op_get;
    assign addr_o  = tl_i.a_address[SramAw+1:2];
    assign wdata_o = tl_i.a_data;

    always_comb begin
        wmask_o = '0;
        for (int k = 0; k < 4; k++) begin
            wmask_o[8*k +: 8] = {8{tl_i.a_mask[k]}};
        end
    end

    always_comb begin
        new_entry         = '0;
        new_entry.opcode  = op_get ? AccessAckData : AccessAck;
        new_entry.size    = tl_i.a_size;
        new_entry.source  = tl_i.a_source;
        new_entry.error   = a_err;
        new_entry.is_read = op_get && !a_err;
    end

    assign head    = entries[rd_ptr];
    assign d_valid = (count != '0) && (!head.is_read || data_valid[rd_ptr]);
    assign pop     = d_valid && tl_i.d_ready;

    always_comb begin
        d_data = 32'h0;
        if (head.is_read) begin
            d_data = rdata_q[rd_ptr];
        end else if (head.error && (head.opcode == AccessAckData)) begin
            d_data = 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = d_valid;
        tl_o.d_opcode = head.opcode;
        tl_o.d_param  = 3'd0;
        tl_o.d_size   = head.size;
        tl_o.d_source = head.source;
        tl_o.d_sink   = 1'b0;
        tl_o.d_data   = d_data;
        tl_o.d_error  = head.error;
    end

    // rd_slot remembers which entry the single in-flight read belongs to, so rvalid_i lands there.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= '0;
            rd_pend    <= 1'b0;
            rd_slot    <= '0;
        end else begin
            rd_pend <= accept && new_entry.is_read;
            if (accept) begin
                rd_slot            <= wr_ptr;
                wr_ptr             <= ptr_next(wr_ptr);
                data_valid[wr_ptr] <= 1'b0;
            end
            if (rd_pend && rvalid_i) begin
                data_valid[rd_slot] <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            entries[wr_ptr] <= new_entry;
        end
        if (rd_pend && rvalid_i) begin
            rdata_q[rd_slot] <= rdata_i;
        end
    end

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:SramAw+2]};

endmodule

// File: tb/tb_tlul_sram_adapter.sv
// tb/tb_tlul_sram_adapter.sv - self-checking bench for tlul_sram_adapter
module tb_tlul_sram_adapter;
    import tlul_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        req_o;
    logic        gnt_i;
    logic        we_o;
    logic [11:0] addr_o;
    logic [31:0] wdata_o;
    logic [31:0] wmask_o;
    logic [31:0] rdata_i  = 32'h0;
    logic        rvalid_i = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    tlul_sram_adapter #(.SramAw(12), .Outstanding(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .tl_i     (tl_i),
        .tl_o     (tl_o),
        .req_o    (req_o),
        .gnt_i    (gnt_i),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .wmask_o  (wmask_o),
        .rdata_i  (rdata_i),
        .rvalid_i (rvalid_i)
    );

    logic [31:0] sram_mem [0:4095];
    logic [31:0] ref_mem  [0:4095];

    typedef struct {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        error;
        logic [31:0] data;
    } resp_t;
    resp_t sb[$];

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [7:0]  src;
        logic        exp_req;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_wmask;
        int          exp_lat;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? 8'hFF : 8'h00;
        return r;
    endfunction

    function automatic logic bench_err(input logic [2:0] op, input logic [1:0] size,
                                       input logic [31:0] addr, input logic [3:0] mask);
        logic [4:0] t;
        logic [3:0] need;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
        if (size > 2) return 1'b1;
        if ((addr & ((32'd1 << size) - 32'd1)) != 32'd0) return 1'b1;
        t    = (5'd1 << (5'd1 << size)) - 5'd1;
        need = t[3:0] << addr[1:0];
        if (op == 3'd0 && ((mask & need) != need)) return 1'b1;
        return 1'b0;
    endfunction

    // SRAM model: writes land at grant, read data one cycle after grant
    always @(posedge clock) begin
        rvalid_i <= 1'b0;
        if (req_o && gnt_i) begin
            if (we_o) sram_mem[addr_o] <= (sram_mem[addr_o] & ~wmask_o) | (wdata_o & wmask_o);
            else begin
                rdata_i  <= sram_mem[addr_o];
                rvalid_i <= 1'b1;
            end
        end
    end

    resp_t       push_r;
    resp_t       pop_r;
    logic        push_get;
    logic [11:0] push_idx;

    always @(negedge clock) begin
        if (!reset && tl_i.a_valid && tl_o.a_ready) begin
            push_get      = (tl_i.a_opcode == 3'd4);
            push_idx      = tl_i.a_address[13:2];
            push_r.opcode = push_get ? 3'd1 : 3'd0;
            push_r.size   = tl_i.a_size;
            push_r.source = tl_i.a_source;
            push_r.error  = bench_err(tl_i.a_opcode, tl_i.a_size, tl_i.a_address, tl_i.a_mask);
            if (push_r.error) push_r.data = push_get ? 32'hFFFF_FFFF : 32'h0;
            else              push_r.data = push_get ? ref_mem[push_idx] : 32'h0;
            if (!push_r.error && !push_get) begin
                ref_mem[push_idx] = (ref_mem[push_idx] & ~expand(tl_i.a_mask))
                                  | (tl_i.a_data & expand(tl_i.a_mask));
            end
            sb.push_back(push_r);
        end
    end

    always @(negedge clock) begin
        if (!reset && tl_o.d_valid && tl_i.d_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_response", tl_o.d_valid, 1'b0);
            end else begin
                pop_r = sb.pop_front();
                check("d_opcode", tl_o.d_opcode, pop_r.opcode);
                check("d_size",   tl_o.d_size,   pop_r.size);
                check("d_source", tl_o.d_source, pop_r.source);
                check("d_error",  tl_o.d_error,  pop_r.error);
                check("d_data",   tl_o.d_data,   pop_r.data);
                check("d_param",  tl_o.d_param,  3'd0);
                check("d_sink",   tl_o.d_sink,   1'b0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                         input bit rnd, output bit acc, output logic s_req, output logic s_we,
                         output logic [11:0] s_addr, output logic [31:0] s_wmask,
                         output logic [31:0] s_wdata);
        acc = 0; s_req = 0; s_we = 0; s_addr = '0; s_wmask = '0; s_wdata = '0;
        @(posedge clock); #1;
        tl_i.a_opcode  = op;
        tl_i.a_size    = size;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
        tl_i.a_valid   = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (rnd) begin
                gnt_i       = 1'($urandom_range(0, 1));
                tl_i.d_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clock);
            if (tl_o.a_ready) begin
                acc = 1; s_req = req_o; s_we = we_o; s_addr = addr_o;
                s_wmask = wmask_o; s_wdata = wdata_o;
                break;
            end
            @(posedge clock); #1;
        end
        if (acc) begin
            @(posedge clock); #1;
        end
        tl_i.a_valid = 1'b0;
        check("request_accepted", acc, 1'b1);
    endtask

    task automatic drain();
        tl_i.d_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        @(posedge clock); #1;
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic wait_d_valid(input string name, input int exp_lat);
        int lat;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (tl_o.d_valid) begin
                lat = k;
                break;
            end
        end
        check(name, lat, exp_lat);
    endtask

    initial begin
        bit          acc;
        logic        s_req, s_we;
        logic [11:0] s_addr;
        logic [31:0] s_wmask, s_wdata;
        int          kind, idx;
        logic [2:0]  r_op;
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        logic [3:0]  r_mask;

        vecs[0]  = '{3'd4, 2'd2, 32'h10, 4'hF, 32'h0,        8'd3,  1, 0, 12'd4, 32'h0,        2};
        vecs[1]  = '{3'd1, 2'd2, 32'h08, 4'h6, 32'h11223344, 8'd1,  1, 1, 12'd2, 32'h00FFFF00, 1};
        vecs[2]  = '{3'd4, 2'd2, 32'h02, 4'hF, 32'h0,        8'd7,  0, 0, 12'd0, 32'h0,        1};
        vecs[3]  = '{3'd4, 2'd2, 32'h08, 4'hF, 32'h0,        8'd5,  1, 0, 12'd2, 32'h0,        2};
        vecs[4]  = '{3'd0, 2'd2, 32'h20, 4'hF, 32'hCAFEF00D, 8'd2,  1, 1, 12'd8, 32'hFFFFFFFF, 1};
        vecs[5]  = '{3'd0, 2'd2, 32'h20, 4'h7, 32'h12345678, 8'd6,  0, 0, 12'd0, 32'h0,        1};
        vecs[6]  = '{3'd3, 2'd2, 32'h00, 4'hF, 32'h0,        8'd8,  0, 0, 12'd0, 32'h0,        1};
        vecs[7]  = '{3'd4, 2'd3, 32'h00, 4'hF, 32'h0,        8'd4,  0, 0, 12'd0, 32'h0,        1};
        vecs[8]  = '{3'd0, 2'd1, 32'h22, 4'hC, 32'hBEEF0000, 8'd9,  1, 1, 12'd8, 32'hFFFF0000, 1};
        vecs[9]  = '{3'd4, 2'd1, 32'h21, 4'hF, 32'h0,        8'd13, 0, 0, 12'd0, 32'h0,        1};
        vecs[10] = '{3'd4, 2'd2, 32'h20, 4'hF, 32'h0,        8'd10, 1, 0, 12'd8, 32'h0,        2};
        vecs[11] = '{3'd1, 2'd0, 32'h23, 4'h8, 32'h5A000000, 8'd11, 1, 1, 12'd8, 32'hFF000000, 1};
        vecs[12] = '{3'd0, 2'd0, 32'h21, 4'h2, 32'h0000AB00, 8'd14, 1, 1, 12'd8, 32'h0000FF00, 1};
        vecs[13] = '{3'd4, 2'd0, 32'h03, 4'h8, 32'h0,        8'd12, 1, 0, 12'd0, 32'h0,        2};

        for (int i = 0; i < 4096; i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        sram_mem[4] = 32'hDEADBEEF;
        ref_mem[4]  = 32'hDEADBEEF;

        tl_i = '0;
        tl_i.d_ready   = 1'b1;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = 3'd4;
        tl_i.a_size    = 2'd2;
        gnt_i          = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_req_o",   req_o,        1'b0);
        check("reset_d_valid", tl_o.d_valid, 1'b0);
        tl_i.a_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("a_ready_after_reset", tl_o.a_ready, 1'b1);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].src,
                  0, acc, s_req, s_we, s_addr, s_wmask, s_wdata);
            check($sformatf("vec%0d_req_o", i), s_req, vecs[i].exp_req);
            if (vecs[i].exp_req) begin
                check($sformatf("vec%0d_addr_o", i), s_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_we_o", i),   s_we,   vecs[i].exp_we);
                if (vecs[i].exp_we) begin
                    check($sformatf("vec%0d_wmask_o", i), s_wmask, vecs[i].exp_wmask);
                    check($sformatf("vec%0d_wdata_o", i), s_wdata, vecs[i].data);
                end
            end
            wait_d_valid($sformatf("vec%0d_latency", i), vecs[i].exp_lat);
        end
        drain();

        // Backpressure: two reads fill the FIFO, the third must wait for a pop.
        tl_i.d_ready   = 1'b0;
        tl_i.a_opcode  = 3'd4;
        tl_i.a_size    = 2'd2;
        tl_i.a_address = 32'h10;
        tl_i.a_mask    = 4'hF;
        tl_i.a_source  = 8'd1;
        tl_i.a_valid   = 1'b1;
        @(negedge clock);
        check("bp_first_ready", tl_o.a_ready, 1'b1);
        @(posedge clock); #1;
        tl_i.a_source = 8'd2;
        @(negedge clock);
        check("bp_second_ready", tl_o.a_ready, 1'b1);
        @(posedge clock); #1;
        tl_i.a_source = 8'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("bp_full_a_ready", tl_o.a_ready,  1'b0);
            check("bp_full_req_o",   req_o,         1'b0);
            check("bp_hold_d_valid", tl_o.d_valid,  1'b1);
            check("bp_hold_source",  tl_o.d_source, 8'd1);
            check("bp_hold_data",    tl_o.d_data,   32'hDEADBEEF);
            @(posedge clock); #1;
        end
        tl_i.d_ready = 1'b1;
        @(negedge clock);
        check("bp_no_bypass", tl_o.a_ready, 1'b0);
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (tl_o.a_ready) begin
                acc = 1;
                break;
            end
        end
        check("bp_third_accepted", acc, 1'b1);
        @(posedge clock); #1;
        tl_i.a_valid = 1'b0;
        drain();

        // Reset while a read is in flight; its rvalid_i arrives after release.
        issue(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd4, 0, acc, s_req, s_we, s_addr, s_wmask, s_wdata);
        reset = 1'b1;
        sb.delete();
        tl_i.a_valid = 1'b1;
        #1;
        check("midrst_req_o",   req_o,        1'b0);
        check("midrst_d_valid", tl_o.d_valid, 1'b0);
        tl_i.a_valid = 1'b0;
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("postrst_d_valid", tl_o.d_valid, 1'b0);
        check("postrst_a_ready", tl_o.a_ready, 1'b1);
        @(negedge clock);
        check("postrst_stale_rvalid", tl_o.d_valid, 1'b0);
        issue(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd6, 0, acc, s_req, s_we, s_addr, s_wmask, s_wdata);
        wait_d_valid("postrst_read_latency", 2);
        drain();

        // Random mix of reads and writes with gnt_i and d_ready toggling.
        for (int i = 0; i < 80; i++) begin
            kind   = $urandom_range(0, 9);
            idx    = $urandom_range(0, 15);
            r_addr = 32'(idx * 4);
            r_size = 2'd2;
            r_mask = 4'hF;
            case (kind)
                0, 1, 2, 3: r_op = 3'd4;
                4, 5:       r_op = 3'd0;
                6, 7: begin
                    r_op   = 3'd1;
                    r_mask = 4'($urandom_range(0, 15));
                end
                8: begin
                    r_op   = 3'd4;
                    r_addr = r_addr + 32'd2;
                end
                default: begin
                    r_op   = 3'd0;
                    r_size = 2'd1;
                    if ($urandom_range(0, 1) == 1) begin
                        r_addr = r_addr + 32'd2;
                        r_mask = 4'hC;
                    end else begin
                        r_mask = 4'h3;
                    end
                end
            endcase
            issue(r_op, r_size, r_addr, r_mask, $urandom, 8'(i), 1,
                  acc, s_req, s_we, s_addr, s_wmask, s_wdata);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running, required finished");
        $fatal(1);
    end

endmodule

// File: doc/tlul_sram_adapter.md
TLUL_SRAM_ADAPTER -- requirements
Module: tlul_sram_adapter

Interface
REQ-001 SHALL have parameter SramAw, default 12: SRAM word-address width.
REQ-002 SHALL have parameter Outstanding, default 2: maximum accepted-but-unanswered requests (FIFO depth, >=1).
REQ-003 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port tl_i, input, tlul_pkg::tl_h2d_t: TL-UL A-channel from host, plus d_ready.
REQ-006 SHALL have port tl_o, output, tlul_pkg::tl_d2h_t: TL-UL D-channel to host, plus a_ready.
REQ-007 SHALL have port req_o, output, 1: SRAM access request.
REQ-008 SHALL have port gnt_i, input, 1: SRAM accepts the access this cycle.
REQ-009 SHALL have port we_o, output, 1: 1 = write, 0 = read.
REQ-010 SHALL have port addr_o, output, SramAw: word address, a_address[SramAw+1:2].
REQ-011 SHALL have port wdata_o, output, 32: equals a_data.
REQ-012 SHALL have port wmask_o, output, 32: a_mask expanded, bit 8k+j = a_mask[k].
REQ-013 SHALL have port rdata_i, input, 32: read data.
REQ-014 SHALL have port rvalid_i, input, 1: read data valid, exactly 1 cycle after a granted read.

Function
REQ-015 SHALL decode opcodes: Get(4) -> AccessAckData(1); PutFullData(0)/PutPartialData(1) -> AccessAck(0).
REQ-016 SHALL flag a request as errored if: opcode not in {0,1,4}; a_size > 2; a_address not aligned to 2^a_size; or PutFullData with a_mask not covering the full a_size span.
REQ-017 SHALL assert a_ready = (count < Outstanding) & (gnt_i | errored); no same-cycle pop bypass when full.
REQ-018 SHALL drive req_o = a_valid & !errored & (count < Outstanding); an errored request never reaches the SRAM.
REQ-019 SHALL count a request accepted when a_valid & a_ready, and push {opcode, size, source, error, is_read} into the response FIFO that cycle.
REQ-020 SHALL capture rdata_i into the head-matching entry's data slot when rvalid_i = 1; rvalid_i without a pending read SHALL be ignored.
REQ-021 SHALL assert d_valid when the FIFO is non-empty and the head is a write, an errored request, or a read whose data is captured.
REQ-022 SHALL return responses strictly in acceptance order.
REQ-023 SHALL drive d_opcode, d_size, d_source from the head entry; d_param = 0; d_sink = 0; d_error = head error bit.
REQ-024 SHALL drive d_data = captured read data for good Gets, 32'hFFFF_FFFF for errored Gets, 0 for AccessAck.
REQ-025 SHALL pop the head when d_valid & d_ready; d_valid and all D fields SHALL hold stable while d_ready = 0.
REQ-026 Latency (d_ready held 1), request accepted in cycle N: write or errored -> d_valid in N+1; read -> d_valid in N+2.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo Outstanding.
REQ-028 With full FIFO, a_ready = 0 and req_o = 0 until a pop completes.

Reset
REQ-029 While reset = 1: FIFO empty, count = 0, all data-valid flags cleared, d_valid = 0, req_o = 0.
REQ-030 A reset asserted mid-operation SHALL discard outstanding entries; no response SHALL be issued for them, and rvalid_i arriving after reset release SHALL be ignored.
REQ-031 After reset release with gnt_i = 1, a_ready SHALL be 1 in the first cycle.

Verification
REQ-032 Get addr 0x10, size 2, source 3; rdata_i = 0xDEADBEEF -> addr_o = 4, we_o = 0, d_valid at N+2, opcode 1, d_data 0xDEADBEEF, d_source 3, d_error 0.
REQ-033 PutPartialData addr 0x8, mask 4'b0110, data 0x11223344 -> wmask_o 0x00FFFF00, we_o = 1, AccessAck at N+1, d_error 0.
REQ-034 Get addr 0x2, size 2 (misaligned) -> req_o never asserted, AccessAckData with d_error 1, d_data 0xFFFFFFFF at N+1.
REQ-035 Three back-to-back Gets, d_ready = 0, Outstanding = 2 -> third held (a_ready = 0); after d_ready = 1, three responses returned in order with correct sources.
REQ-036 Reset pulse with one read outstanding -> d_valid = 0, count = 0; next Get completes normally with correct data.
REQ-037 Alternating Put/Get with gnt_i toggling randomly; scoreboard checks in-order responses and data against a memory model.
